mpd_prj_switch_ctrl: RTL and testbench



---
 rtl/mpd_prj_switch_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mpd_prj_switch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpd_prj_switch_ctrl.sv
// Project-switch controller: debounces the fabric's project request and sequences
// IO isolation, user reset and release around each change of prj_sel.
// Optional heartbeat divider is built only when MPD_PRJ_HEARTBEAT_EN is defined.
module mpd_prj_switch_ctrl #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned ISO_CYCLES    = 2,
   parameter int unsigned RST_CYCLES    = 8,
   parameter int unsigned NUM_PRJ       = 10,
   parameter int unsigned HB_DIV_BITS   = 22
) (
   input  logic       CLK,
   input  logic       por,
   input  logic       fabric_done,
   input  logic [3:0] prj_sel_req,
   output logic [3:0] prj_sel,
   output logic       prj_rst,
   output logic       prj_en,
   output logic       busy,
   output logic [7:0] switch_cnt,
   output logic       heart_led
);

   if (STABLE_CYCLES < 1 || STABLE_CYCLES > 15) begin : g_bad_stable
      $error("STABLE_CYCLES out of range 1..15");
   end
   if (ISO_CYCLES < 1 || ISO_CYCLES > 15) begin : g_bad_iso
      $error("ISO_CYCLES out of range 1..15");
   end
   if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst
      $error("RST_CYCLES out of range 1..255");
   end
   if (NUM_PRJ < 1 || NUM_PRJ > 16) begin : g_bad_num
      $error("NUM_PRJ out of range 1..16");
   end
   if (HB_DIV_BITS < 1) begin : g_bad_hb
      $error("HB_DIV_BITS must be at least 1");
   end

   localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);
   localparam logic [4:0] NUM_PRJ_W  = 5'(NUM_PRJ);
   localparam logic [7:0] ISO_LAST   = 8'(ISO_CYCLES - 1);
   localparam logic [7:0] RST_LAST   = 8'(RST_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_RESET,
      ST_RELEASE,
      ST_ACTIVE
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] req_q, req_d;
   logic [3:0] stab_q, stab_d;
   logic [3:0] pend_q, pend_d;
   logic [3:0] sel_q, sel_d;
   logic [7:0] tmr_q, tmr_d;
   logic [7:0] cnt_q, cnt_d;
   logic       rst_q, rst_d;
   logic       en_q, en_d;
   logic       busy_q, busy_d;

   logic       req_in_range;
   logic       req_ok;

   // Request debounce: run length of identical samples, saturating.
   always_comb begin
      req_d = prj_sel_req;
      if (prj_sel_req != req_q) begin
         stab_d = '0;
      end else if (stab_q == STABLE_MAX) begin
         stab_d = stab_q;
      end else begin
         stab_d = stab_q + 4'd1;
      end
   end

   assign req_in_range = ({1'b0, req_q} < NUM_PRJ_W);
   assign req_ok       = (stab_q == STABLE_MAX) && (req_q != sel_q) && req_in_range;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      pend_d  = pend_q;
      tmr_d   = tmr_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (fabric_done) begin
               state_d = ST_RESET;
               tmr_d   = '0;
               sel_d   = req_in_range ? req_q : '0;
            end
         end
         ST_ACTIVE: begin
            if (req_ok) begin
               state_d = ST_DRAIN;
               pend_d  = req_q;
               tmr_d   = '0;
            end
         end
         ST_DRAIN: begin
            if (tmr_q == ISO_LAST) begin
               state_d = ST_RESET;
               tmr_d   = '0;
               sel_d   = pend_q;
            end else begin
               tmr_d = tmr_q + 8'd1;
            end
         end
         ST_RESET: begin
            if (tmr_q == RST_LAST) begin
               state_d = ST_RELEASE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 8'd1;
            end
         end
         ST_RELEASE: begin
            state_d = ST_ACTIVE;
            cnt_d   = cnt_q + 8'd1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Loss of fabric_done wins over any transition, including its side effects.
      if (!fabric_done) begin
         state_d = ST_IDLE;
         sel_d   = sel_q;
         pend_d  = pend_q;
         cnt_d   = cnt_q;
         tmr_d   = '0;
      end

      rst_d  = (state_d == ST_IDLE) || (state_d == ST_RESET);
      en_d   = (state_d == ST_ACTIVE);
      busy_d = (state_d != ST_ACTIVE);
   end

   always_ff @(posedge CLK or posedge por) begin
      if (por) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         stab_q  <= '0;
         pend_q  <= '0;
         sel_q   <= '0;
         tmr_q   <= '0;
         cnt_q   <= '0;
         rst_q   <= 1'b1;
         en_q    <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         stab_q  <= stab_d;
         pend_q  <= pend_d;
         sel_q   <= sel_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         rst_q   <= rst_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
      end
   end

   assign prj_sel    = sel_q;
   assign prj_rst    = rst_q;
   assign prj_en     = en_q;
   assign busy       = busy_q;
   assign switch_cnt = cnt_q;

`ifdef MPD_PRJ_HEARTBEAT_EN
   localparam logic [HB_DIV_BITS-1:0] HB_ONE = HB_DIV_BITS'(1);

   logic [HB_DIV_BITS-1:0] div_q, div_d;
   logic                   led_q, led_d;

   // Divider only advances while a project is running; LED flips on each wrap.
   always_comb begin
      div_d = div_q;
      led_d = led_q;
      if (state_q == ST_ACTIVE) begin
         div_d = div_q + HB_ONE;
         if (&div_q) begin
            led_d = ~led_q;
         end
      end
   end

   always_ff @(posedge CLK or posedge por) begin
      if (por) begin
         div_q <= '0;
         led_q <= 1'b0;
      end else begin
         div_q <= div_d;
         led_q <= led_d;
      end
   end

   assign heart_led = led_q;
`else
   assign heart_led = 1'b0;
`endif

endmodule

// File: tb/tb_mpd_prj_switch_ctrl.sv
// Bench for mpd_prj_switch_ctrl: timeline-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_mpd_prj_switch_ctrl;

   localparam int P_STABLE = 4;
   localparam int P_ISO    = 2;
   localparam int P_RST    = 8;
   localparam int P_NUM    = 10;
   localparam int P_HB     = 4;

   logic       CLK = 1'b0;
   logic       por;
   logic       fabric_done;
   logic [3:0] prj_sel_req;
   logic [3:0] prj_sel;
   logic       prj_rst;
   logic       prj_en;
   logic       busy;
   logic [7:0] switch_cnt;
   logic       heart_led;

   always #5 CLK = ~CLK;

   mpd_prj_switch_ctrl #(
      .STABLE_CYCLES(P_STABLE),
      .ISO_CYCLES   (P_ISO),
      .RST_CYCLES   (P_RST),
      .NUM_PRJ      (P_NUM),
      .HB_DIV_BITS  (P_HB)
   ) dut (
      .CLK        (CLK),
      .por        (por),
      .fabric_done(fabric_done),
      .prj_sel_req(prj_sel_req),
      .prj_sel    (prj_sel),
      .prj_rst    (prj_rst),
      .prj_en     (prj_en),
      .busy       (busy),
      .switch_cnt (switch_cnt),
      .heart_led  (heart_led)
   );

   int total = 0;
   int bad   = 0;
   bit cmp_on = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a switch is a timeline t = 0.. measured from DRAIN start;
   // bring-up from idle enters that timeline at t = ISO (no drain phase).
   bit m_idle;
   bit m_sw;
   int m_t;
   int m_sel;
   int m_pend;
   int m_cnt;
   int m_nact;
   int hist[$];

   function automatic void model_reset();
      m_idle = 1; m_sw = 0; m_t = 0;
      m_sel = 0; m_pend = 0; m_cnt = 0; m_nact = 0;
      hist = {};
      hist.push_back(0);
   endfunction

   function automatic bit stable_req();
      if (hist.size() != P_STABLE + 1) return 0;
      foreach (hist[i]) if (hist[i] != hist[0]) return 0;
      return 1;
   endfunction

   function automatic void model_step();
      int rq;
      rq = hist[hist.size() - 1];
      if (!m_idle && !m_sw) m_nact++;
      if (!fabric_done) begin
         m_idle = 1;
         m_sw   = 0;
      end else if (m_idle) begin
         m_idle = 0;
         m_sw   = 1;
         m_t    = P_ISO;
         m_sel  = (rq < P_NUM) ? rq : 0;
      end else if (m_sw) begin
         m_t++;
         if (m_t == P_ISO) m_sel = m_pend;
         if (m_t == P_ISO + P_RST + 1) begin
            m_sw  = 0;
            m_cnt = (m_cnt + 1) % 256;
         end
      end else if (stable_req() && rq != m_sel && rq < P_NUM) begin
         m_sw   = 1;
         m_t    = 0;
         m_pend = rq;
      end
      hist.push_back(int'(prj_sel_req));
      if (hist.size() > P_STABLE + 1) void'(hist.pop_front());
   endfunction

   initial forever begin
      @(posedge CLK);
      if (por) model_reset();
      else model_step();
   end

   initial forever begin
      @(negedge CLK);
      if (cmp_on) begin
         bit act;
         int exp_heart;
         act = !m_idle && !m_sw;
`ifdef MPD_PRJ_HEARTBEAT_EN
         exp_heart = (m_nact >> P_HB) & 1;
`else
         exp_heart = 0;
`endif
         chk("prj_sel", prj_sel, m_sel);
         chk("prj_en", prj_en, act);
         chk("prj_rst", prj_rst, int'(m_idle || (m_sw && m_t >= P_ISO && m_t < P_ISO + P_RST)));
         chk("busy", busy, !act);
         chk("switch_cnt", switch_cnt, m_cnt);
         chk("heart_led", heart_led, exp_heart);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
      #1;
   endtask

   // Waits for prj_en (which=0) or prj_rst (which=1) to reach val; n counts the
   // negedge samples taken including the one where the level was seen.
   task automatic wait_sig(input int which, input bit val, input int maxc, output int n);
      logic cur;
      n = 0;
      forever begin
         @(negedge CLK);
         n++;
         cur = (which == 1) ? prj_rst : prj_en;
         if (cur === val) break;
         if (n >= maxc) begin
            total++;
            bad++;
            $display("FAIL wait_%s: got %b after %0d cycles, required %b",
                     (which == 1) ? "prj_rst" : "prj_en", cur, n, val);
            break;
         end
      end
      #1;
   endtask

   task automatic do_por();
      por = 1'b1;
      model_reset();
      step(2);
      por = 1'b0;
   endtask

   initial begin
      int n;
      int r;
      por         = 1'b1;
      fabric_done = 1'b0;
      prj_sel_req = 4'd3;
      model_reset();
      cmp_on = 1;
      step(3);
      chk("por_prj_rst", prj_rst, 1);
      chk("por_prj_en", prj_en, 0);
      chk("por_busy", busy, 1);
      chk("por_sel", prj_sel, 0);
      chk("por_cnt", switch_cnt, 0);
      chk("por_heart", heart_led, 0);

      // Bring-up: IDLE -> RESET(8) -> RELEASE(1) -> ACTIVE
      por = 1'b0;
      step(3);
      fabric_done = 1'b1;
      wait_sig(0, 1'b1, 50, n);
      chk("bringup_latency", n, 10);
      chk("bringup_sel", prj_sel, 3);
      chk("bringup_cnt", switch_cnt, 1);

      // Toggling request never stabilises; out-of-range request is ignored.
      for (int i = 0; i < 20; i++) begin
         prj_sel_req = (i % 2 == 0) ? 4'd5 : 4'd3;
         step(2);
      end
      chk("toggle_sel", prj_sel, 3);
      chk("toggle_busy", busy, 0);
      prj_sel_req = 4'd12;
      step(100);
      chk("oor_sel", prj_sel, 3);
      chk("oor_busy", busy, 0);

      // Normal switch 3 -> 5
      prj_sel_req = 4'd5;
      wait_sig(0, 1'b0, 50, n);
      chk("accept_latency", n, 6);
      chk("drain_rst", prj_rst, 0);
      wait_sig(1, 1'b1, 50, n);
      chk("drain_len", n, 2);
      chk("reset_entry_sel", prj_sel, 5);
      wait_sig(1, 1'b0, 50, n);
      chk("reset_len", n, 8);
      chk("release_en", prj_en, 0);
      wait_sig(0, 1'b1, 50, n);
      chk("release_len", n, 1);
      chk("switch2_cnt", switch_cnt, 2);

      // fabric_done dropped during RESET
      prj_sel_req = 4'd7;
      wait_sig(1, 1'b1, 50, n);
      step(1);
      fabric_done = 1'b0;
      step(1);
      chk("drop_rst", prj_rst, 1);
      chk("drop_en", prj_en, 0);
      chk("drop_busy", busy, 1);
      chk("drop_cnt", switch_cnt, 2);
      step(3);
      fabric_done = 1'b1;
      wait_sig(0, 1'b1, 50, n);
      chk("reraise_latency", n, 10);
      chk("reraise_sel", prj_sel, 7);
      chk("reraise_cnt", switch_cnt, 3);

      // Bring-up with out-of-range request selects project 0
      fabric_done = 1'b0;
      prj_sel_req = 4'd13;
      step(4);
      fabric_done = 1'b1;
      wait_sig(0, 1'b1, 50, n);
      chk("oor_bringup_sel", prj_sel, 0);
      chk("oor_bringup_cnt", switch_cnt, 4);
      step(30);
      chk("oor_hold_busy", busy, 0);

      // Request held through a switch is taken on the first ACTIVE cycle
      prj_sel_req = 4'd2;
      wait_sig(1, 1'b1, 50, n);
      prj_sel_req = 4'd4;
      wait_sig(0, 1'b1, 50, n);
      wait_sig(0, 1'b0, 50, n);
      chk("first_active_len", n, 1);
      wait_sig(0, 1'b1, 50, n);
      chk("held_sel", prj_sel, 4);
      chk("held_cnt", switch_cnt, 6);

      // Randomized traffic with occasional fabric_done drops and por pulses
      for (int it = 0; it < 150; it++) begin
         r = $urandom_range(0, 19);
         if (r == 0) begin
            do_por();
            step($urandom_range(1, 4));
         end else if (r <= 2) begin
            fabric_done = 1'b0;
            step($urandom_range(1, 5));
            fabric_done = 1'b1;
         end else begin
            prj_sel_req = 4'($urandom_range(0, 15));
            step($urandom_range(1, 25));
         end
      end

      // 255 switches after bring-up wrap switch_cnt to 0
      fabric_done = 1'b0;
      prj_sel_req = 4'd1;
      do_por();
      step(2);
      fabric_done = 1'b1;
      wait_sig(0, 1'b1, 50, n);
      chk("wrap_start_cnt", switch_cnt, 1);
      for (int i = 0; i < 255; i++) begin
         prj_sel_req = (i % 2 == 0) ? 4'd2 : 4'd1;
         wait_sig(0, 1'b0, 60, n);
         wait_sig(0, 1'b1, 60, n);
      end
      chk("wrap_cnt", switch_cnt, 0);
      chk("wrap_sel", prj_sel, 2);
`ifndef MPD_PRJ_HEARTBEAT_EN
      chk("heart_off", heart_led, 0);
`endif

      cmp_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached at t=%0t, required completion earlier", $time);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
